glitch_scheduler: RTL and testbench

Programmable timing controller sitting directly upstream of the glitch injector. Once armed, it waits for a trigger edge, counts a configurable delay, then drives the injector's `enable` (random scramble) or `enable_specific` (forced value) for a programmed width. It repeats this for a programmed number of glitches with a programmed gap between them, and signals completion. It gives fault-injection benches cycle-accurate, repeatable glitch placement relative to a core event.

---
 rtl/glitch_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_glitch_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/glitch_scheduler.sv
// Timing controller ahead of the glitch injector: arm, wait for trigger, delay, then a burst of glitches.
// Define GLITCH_SCHED_LFSR_EN to add LFSR-based jitter to the trigger-to-glitch delay.
module glitch_scheduler #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               abort,
  input  logic               trigger,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [DELAY_W-1:0] cfg_gap,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic               cfg_specific,
  input  logic [DELAY_W-1:0] cfg_jitter_mask,
  output logic               enable,
  output logic               enable_specific,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] glitch_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    DELAY  = 3'd2,
    GLITCH = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [DELAY_W-1:0] cnt_r, cnt_nxt_s;
  logic [COUNT_W-1:0] glitch_cnt_r, glitch_cnt_nxt_s, glitch_cnt_inc_s;
  logic [DELAY_W-1:0] delay_r, gap_last_r, eff_delay_r, eff_delay_s;
  logic [WIDTH_W-1:0] width_last_r;
  logic [COUNT_W-1:0] count_r;
  logic               gap_zero_r, specific_r, trigger_q_r;
  logic               trig_edge_s, latch_s, capture_s, done_nxt_s;
  logic               enable_r, enable_specific_r, busy_r, done_r;

`ifdef GLITCH_SCHED_LFSR_EN
  logic [15:0]        lfsr_r;
  logic [DELAY_W-1:0] mask_r;
  logic [DELAY_W:0]   jitter_sum_s;

  // Free-running jitter source; the mask is captured with the rest of the config
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_r <= 16'hACE1;
      mask_r <= {DELAY_W{1'b0}};
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      if (latch_s) begin
        mask_r <= cfg_jitter_mask;
      end
    end
  end

  assign jitter_sum_s = {1'b0, delay_r} + {1'b0, DELAY_W'(lfsr_r) & mask_r};
  assign eff_delay_s  = jitter_sum_s[DELAY_W] ? {DELAY_W{1'b1}} : jitter_sum_s[DELAY_W-1:0];
`else
  logic unused_jitter_s;
  assign unused_jitter_s = ^cfg_jitter_mask;
  assign eff_delay_s     = delay_r;
`endif

  assign trig_edge_s      = trigger & ~trigger_q_r;
  assign glitch_cnt_inc_s = (glitch_cnt_r == {COUNT_W{1'b1}}) ? glitch_cnt_r
                                                               : glitch_cnt_r + COUNT_W'(1);

  // Burst configuration, normalised at arm time so zero width/count mean one
  always_ff @(posedge clk) begin
    if (!reset) begin
      delay_r      <= {DELAY_W{1'b0}};
      width_last_r <= {WIDTH_W{1'b0}};
      gap_last_r   <= {DELAY_W{1'b0}};
      gap_zero_r   <= 1'b1;
      count_r      <= COUNT_W'(1);
      specific_r   <= 1'b0;
    end else if (latch_s) begin
      delay_r      <= cfg_delay;
      width_last_r <= (cfg_width == {WIDTH_W{1'b0}}) ? {WIDTH_W{1'b0}} : cfg_width - WIDTH_W'(1);
      gap_last_r   <= cfg_gap - DELAY_W'(1);
      gap_zero_r   <= (cfg_gap == {DELAY_W{1'b0}});
      count_r      <= (cfg_count == {COUNT_W{1'b0}}) ? COUNT_W'(1) : cfg_count;
      specific_r   <= cfg_specific;
    end
  end

  // Next-state and counter updates; abort overrides every state
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    glitch_cnt_nxt_s = glitch_cnt_r;
    done_nxt_s       = 1'b0;
    latch_s          = 1'b0;
    capture_s        = 1'b0;
    if (abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (arm) begin
            state_nxt_s      = ARMED;
            latch_s          = 1'b1;
            glitch_cnt_nxt_s = {COUNT_W{1'b0}};
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ARMED: begin
          if (trig_edge_s) begin
            state_nxt_s = DELAY;
            cnt_nxt_s   = {DELAY_W{1'b0}};
            capture_s   = 1'b1;
          end else begin
            state_nxt_s = ARMED;
          end
        end
        DELAY: begin
          if (cnt_r == eff_delay_r) begin
            state_nxt_s = GLITCH;
            cnt_nxt_s   = {DELAY_W{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + DELAY_W'(1);
          end
        end
        GLITCH: begin
          if (cnt_r == DELAY_W'(width_last_r)) begin
            glitch_cnt_nxt_s = glitch_cnt_inc_s;
            cnt_nxt_s        = {DELAY_W{1'b0}};
            if (glitch_cnt_inc_s < count_r) begin
              state_nxt_s = gap_zero_r ? GLITCH : GAP;
            end else begin
              state_nxt_s = IDLE;
              done_nxt_s  = 1'b1;
            end
          end else begin
            cnt_nxt_s = cnt_r + DELAY_W'(1);
          end
        end
        GAP: begin
          if (cnt_r == gap_last_r) begin
            state_nxt_s = GLITCH;
            cnt_nxt_s   = {DELAY_W{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + DELAY_W'(1);
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs (outputs decoded from the next state)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r           <= IDLE;
      cnt_r             <= {DELAY_W{1'b0}};
      glitch_cnt_r      <= {COUNT_W{1'b0}};
      eff_delay_r       <= {DELAY_W{1'b0}};
      trigger_q_r       <= 1'b0;
      enable_r          <= 1'b0;
      enable_specific_r <= 1'b0;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
    end else begin
      state_r           <= state_nxt_s;
      cnt_r             <= cnt_nxt_s;
      glitch_cnt_r      <= glitch_cnt_nxt_s;
      trigger_q_r       <= trigger;
      enable_r          <= (state_nxt_s == GLITCH) & ~specific_r;
      enable_specific_r <= (state_nxt_s == GLITCH) & specific_r;
      busy_r            <= (state_nxt_s != IDLE);
      done_r            <= done_nxt_s;
      if (capture_s) begin
        eff_delay_r <= eff_delay_s;
      end
    end
  end

  assign enable          = enable_r;
  assign enable_specific = enable_specific_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign glitch_cnt      = glitch_cnt_r;

endmodule

// File: tb/tb_glitch_scheduler.sv
// Randomised bench for glitch_scheduler; expected waveforms come from the burst timing
// rules (pulse k occupies edges S_k .. S_k+W-1, S_k = N+1+D+k*(W+G)).
module tb_glitch_scheduler;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, arm, abort, trigger, cfg_specific;
  logic [DW-1:0] cfg_delay, cfg_gap, cfg_jitter_mask;
  logic [WW-1:0] cfg_width;
  logic [CW-1:0] cfg_count;
  logic          enable, enable_specific, busy, done;
  logic [CW-1:0] glitch_cnt;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  glitch_scheduler #(.DELAY_W(DW), .WIDTH_W(WW), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
    .cfg_count(cfg_count), .cfg_specific(cfg_specific),
    .cfg_jitter_mask(cfg_jitter_mask),
    .enable(enable), .enable_specific(enable_specific), .busy(busy),
    .done(done), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit pulse_on(int t, int n, int d, int w, int g, int c);
    for (int k = 0; k < c; k++) begin
      int s = n + 1 + d + k * (w + g);
      if (t >= s && t < s + w) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int pulses_done(int t, int n, int d, int w, int g, int c);
    int m = 0;
    for (int k = 0; k < c; k++) begin
      if (n + 1 + d + k * (w + g) + w <= t) m++;
    end
    return m;
  endfunction

  function automatic logic [DW-1:0] exact_mask();
`ifdef GLITCH_SCHED_LFSR_EN
    return {DW{1'b0}};
`else
    return DW'($urandom);
`endif
  endfunction

  // abort_rel < 0: no abort; otherwise abort sampled at edge N+abort_rel
  task automatic run_burst(input int d, input int w, input int g, input int c, input bit sp,
                           input int pre, input int abort_rel, input bit noise);
    int a_e, n_e, we, ce, m_e, d_e, t_end, lim;
    bit on;
    we = (w == 0) ? 1 : w;
    ce = (c == 0) ? 1 : c;
    @(negedge clk);
    cfg_delay = DW'(d); cfg_width = WW'(w); cfg_gap = DW'(g); cfg_count = CW'(c);
    cfg_specific = sp; cfg_jitter_mask = exact_mask();
    arm = 1'b1; trigger = 1'b0; abort = 1'b0;
    a_e   = cyc + 1;
    n_e   = a_e + pre;
    d_e   = n_e + 1 + d + (ce - 1) * (we + g) + we;
    m_e   = (abort_rel < 0) ? 32'h3fff_ffff : n_e + abort_rel;
    t_end = ((m_e < d_e) ? m_e : d_e) + 3;
    for (int t = a_e; t <= t_end; t++) begin
      @(negedge clk);
      on  = pulse_on(t, n_e, d, we, g, ce) && (t < m_e);
      lim = (t < m_e) ? t : m_e - 1;
      chk_eq("busy", busy, (t < d_e) && (t < m_e));
      chk_eq("enable", enable, on & ~sp);
      chk_eq("enable_specific", enable_specific, on & sp);
      chk_eq("done", done, (t == d_e) && (t < m_e));
      chk_eq("glitch_cnt", glitch_cnt, pulses_done(lim, n_e, d, we, g, ce));
      arm   = noise && (t < d_e) && (t < m_e) && ($urandom_range(3, 0) == 0);
      abort = (t + 1 == m_e);
      if (t + 1 < n_e) trigger = 1'b0;
      else if (t + 1 == n_e) trigger = 1'b1;
      else trigger = noise ? 1'($urandom_range(1, 0)) : 1'b1;
      if (noise) begin
        cfg_delay = DW'($urandom); cfg_width = WW'($urandom); cfg_gap = DW'($urandom);
        cfg_count = CW'($urandom); cfg_specific = 1'($urandom_range(1, 0));
        cfg_jitter_mask = DW'($urandom);
      end
    end
    arm = 1'b0; abort = 1'b0;
  endtask

  initial begin
    int d, w, g, c, pre, ab, len, n_e, off, mn, mx;
    reset = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0; cfg_specific = 1'b0;
    cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_count = '0; cfg_jitter_mask = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_enable", enable, 1'b0);
    chk_eq("rst_enable_specific", enable_specific, 1'b0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_done", done, 1'b0);
    chk_eq("rst_glitch_cnt", glitch_cnt, '0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      trigger = ~trigger;
      @(negedge clk);
      chk_eq("noarm_enable", enable | enable_specific, 1'b0);
      chk_eq("noarm_busy", busy, 1'b0);
    end

    run_burst(5, 3, 0, 1, 1'b0, 2, -1, 1'b0);  // single glitch
    run_burst(0, 2, 4, 3, 1'b1, 1, -1, 1'b0);  // burst
    run_burst(2, 0, 0, 0, 1'b0, 3, -1, 1'b0);  // zero width/count/gap
    run_burst(1, 3, 0, 2, 1'b1, 1, -1, 1'b0);  // back-to-back pulses
    run_burst(1, 3, 2, 3, 1'b0, 2, 8, 1'b1);   // abort inside second glitch
    run_burst(3, 2, 1, 2, 1'b1, 1, -1, 1'b1);  // re-arm after abort, with noise

    for (int b = 0; b < 40; b++) begin
      d = $urandom_range(8, 0); w = $urandom_range(4, 0); g = $urandom_range(4, 0);
      c = $urandom_range(4, 0); pre = $urandom_range(4, 1);
      len = d + 1 + (((c == 0) ? 1 : c)) * (((w == 0) ? 1 : w) + g);
      ab  = ($urandom_range(3, 0) == 0) ? $urandom_range(len + 1, 0) : -1;
      run_burst(d, w, g, c, 1'($urandom_range(1, 0)), pre, ab, 1'b1);
    end

    // Reset mid-glitch must drop the enable at that edge
    @(negedge clk);
    cfg_delay = '0; cfg_width = 8'd8; cfg_gap = '0; cfg_count = 8'd1; cfg_specific = 1'b0;
    cfg_jitter_mask = '0; arm = 1'b1; trigger = 1'b0;
    @(negedge clk);
    arm = 1'b0; trigger = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("prerst_enable", enable, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk_eq("midrst_enable", enable, 1'b0);
    chk_eq("midrst_busy", busy, 1'b0);
    chk_eq("midrst_glitch_cnt", glitch_cnt, '0);
    reset = 1'b1; trigger = 1'b0;

`ifdef GLITCH_SCHED_LFSR_EN
    mn = 1 << 30; mx = -1;
    for (int b = 0; b < 50; b++) begin
      repeat ($urandom_range(3, 1)) @(negedge clk);
      cfg_delay = 16'd3; cfg_width = 8'd1; cfg_gap = '0; cfg_count = 8'd1;
      cfg_specific = 1'b0; cfg_jitter_mask = 16'h000F; arm = 1'b1; trigger = 1'b0;
      @(negedge clk);
      arm = 1'b0; trigger = 1'b1;
      n_e = cyc + 1;
      off = -1;
      for (int k = 0; k < 40 && off < 0; k++) begin
        @(negedge clk);
        if (enable) off = cyc - n_e - 1 - 3;
      end
      chk_eq("jitter_seen", off >= 0, 1'b1);
      chk_eq("jitter_range", (off >= 0) && (off <= 15), 1'b1);
      if (off >= 0 && off < mn) mn = off;
      if (off > mx) mx = off;
      repeat (4) @(negedge clk);
      trigger = 1'b0;
    end
    chk_eq("jitter_varies", mx > mn, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
